// File: rtl/instr_loader.sv
// Program loader: receives a framed byte stream (length, big-endian words, XOR checksum)
// and writes the words into instruction memory while holding the CPU stalled.
module instr_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_HI = 4'd1;
    localparam logic [3:0] S_LEN_LO = 4'd2;
    localparam logic [3:0] S_DAT_HI = 4'd3;
    localparam logic [3:0] S_DAT_LO = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
    localparam logic [3:0] S_CSUM   = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [3:0]  state_q,    state_d;
    logic [7:0]  len_hi_q,   len_hi_d;
    logic [15:0] length_q,   length_d;
    logic [7:0]  dat_hi_q,   dat_hi_d;
    logic [7:0]  csum_q,     csum_d;
    logic        wr_en_q,    wr_en_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [15:0] wr_data_q,  wr_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        error_q,    error_d;
    logic [8:0]  words_q,    words_d;

    logic        xfer;
    logic [15:0] len_rx;
    logic [8:0]  words_inc;

    always_comb begin
        in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DAT_HI) || (state_q == S_DAT_LO) ||
                   (state_q == S_CSUM);
    end

    assign xfer      = in_valid && in_ready;
    assign len_rx    = {len_hi_q, in_data};
    assign words_inc = words_q + 9'd1;

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        length_d   = length_q;
        dat_hi_d   = dat_hi_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        words_d    = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // in_ready is low here, so a byte arriving with start is left for LEN_HI
                if (start) begin
                    state_d    = S_LEN_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
                    csum_d     = '0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if ((len_rx == 16'd0) || ({1'b0, len_rx} > DEPTH_W)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        length_d = len_rx;
                        state_d  = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (xfer) begin
                    dat_hi_d = in_data;
                    csum_d   = csum_q ^ in_data;
                    state_d  = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                // Write strobe is registered here so it is visible during the WRITE cycle
                if (xfer) begin
                    csum_d    = csum_q ^ in_data;
                    wr_data_d = {dat_hi_q, in_data};
                    wr_addr_d = BASE_ADDR + {6'b0, words_q, 1'b0};
                    wr_en_d   = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                words_d = words_inc;
                if ({7'b0, words_inc} == length_q) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DAT_HI;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            length_q   <= '0;
            dat_hi_q   <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            length_q   <= length_d;
            dat_hi_q   <= dat_hi_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: stream-level model predicts writes and load outcome.
module tb_instr_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [15:0] BASE  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [8:0]  idx;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wlog[$];
    bit          noise = 1'b0;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [15:0] w[$]);
        logic [7:0] x = '0;
        foreach (w[i]) x ^= w[i][15:8] ^ w[i][7:0];
        return x;
    endfunction

    // Compare process: every write is checked against the predicted write list
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("words_at_write", words_loaded, e.idx);
                end
                wlog.push_back({wr_addr, wr_data});
            end
            chk("busy_implies_hold", busy && !cpu_hold, 0);
            chk("done_and_error", done && error, 0);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit sent = 1'b0;
        int n = 0;
        while (!sent) begin
            @(negedge clk);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? b : 8'($urandom);
            start    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            sent     = in_valid && in_ready;
            n++;
            if (!sent && n > 1000) begin
                chk("byte_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    task automatic do_start(input bit with_byte);
        @(negedge clk);
        start = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk("in_ready_on_restart", in_ready, 0);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_words", words_loaded, 0);
    endtask

    task automatic run_load(input int len, input logic [15:0] w[$], input logic [7:0] ck,
                            input bit rnd, input bit with_noise, input bit restart_byte);
        logic [15:0] l16 = 16'(len);
        bit valid = (len >= 1) && (len <= int'(DEPTH));
        bit ok;
        int n = 0;
        do_start(restart_byte);
        if (valid) begin
            for (int i = 0; i < len; i++)
                exp_q.push_back('{addr: BASE + 16'(2 * i), data: w[i], idx: 9'(i)});
        end
        ok = valid && (ck == csum_of(w));
        noise = with_noise;
        send_byte(l16[15:8], rnd);
        send_byte(l16[7:0], rnd);
        if (valid) begin
            for (int i = 0; i < len; i++) begin
                send_byte(w[i][15:8], rnd);
                send_byte(w[i][7:0], rnd);
            end
            send_byte(ck, rnd);
        end
        noise = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("outcome_timeout", (n >= 50), 0);
        chk("end_done", done, ok);
        chk("end_error", error, !ok);
        chk("end_hold", cpu_hold, !ok);
        chk("end_busy", busy, 0);
        chk("end_words", words_loaded, valid ? len : 0);
        chk("end_in_ready", in_ready, 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] w[$];
        #2;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        // 1: two-word program, XOR of data bytes 20^40^24^85 = C1
        w = {16'h2040, 16'h2485};
        run_load(2, w, 8'hC1, 1'b0, 1'b0, 1'b0);
        chk("t1_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t1_write0", wlog[0], 32'h0000_2040);
            chk("t1_write1", wlog[1], 32'h0002_2485);
        end

        // 2: zero length, then 257 (restart from DONE/ERROR with a byte present)
        w = {};
        run_load(0, w, 8'h00, 1'b0, 1'b0, 1'b1);
        run_load(257, w, 8'h00, 1'b0, 1'b0, 1'b1);

        // 3: single word with bad checksum
        w = {16'hD004};
        run_load(1, w, 8'h00, 1'b0, 1'b0, 1'b1);

        // 4: full-depth load with random valid gaps
        w = {};
        for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
        wlog = {};
        run_load(256, w, csum_of(w), 1'b1, 1'b0, 1'b0);
        chk("t4_nwrites", wlog.size(), 256);
        if (wlog.size() == 256) begin
            chk("t4_first_addr", wlog[0][31:16], 16'h0000);
            chk("t4_last_addr", wlog[255][31:16], 16'h01FE);
        end

        // 5: reset mid-load after three words
        w = {};
        for (int i = 0; i < 10; i++) w.push_back(16'($urandom));
        do_start(1'b0);
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{addr: BASE + 16'(2 * i), data: w[i], idx: 9'(i)});
        send_byte(8'h00, 1'b1);
        send_byte(8'd10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_byte(w[i][15:8], 1'b1);
            send_byte(w[i][7:0], 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_pending_before_reset", exp_q.size(), 0);
        chk("t5_words_before_reset", words_loaded, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        w = {};
        for (int i = 0; i < 4; i++) w.push_back(16'($urandom));
        run_load(4, w, csum_of(w), 1'b1, 1'b0, 1'b0);

        // 6: start pulses while busy are ignored
        w = {};
        for (int i = 0; i < 12; i++) w.push_back(16'($urandom));
        run_load(12, w, csum_of(w), 1'b1, 1'b1, 1'b0);

        // Random mix of lengths and checksum faults
        for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(1, 20);
            logic [7:0] ck;
            w = {};
            for (int i = 0; i < len; i++) w.push_back(16'($urandom));
            ck = csum_of(w);
            if ($urandom_range(0, 2) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
            run_load(len, w, ck, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
